// File: rtl/timing_interrupt_sequencer.sv
// Timing and I/O-interrupt sequencer: sequence counter, start/stop flip-flop,
// one-hot timing outputs, interrupt cycle control and keyboard/printer flags.
module timing_interrupt_sequencer #(
   parameter int IO_W = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            hlt,
   input  logic            sc_clr,
   input  logic            ion,
   input  logic            iof,
   input  logic            inp_ack,
   input  logic            out_load,
   input  logic [IO_W-1:0] ac_low,
   input  logic            kbd_valid,
   input  logic [IO_W-1:0] kbd_data,
   output logic            kbd_ready,
   output logic            prt_valid,
   input  logic            prt_ready,
   output logic [IO_W-1:0] prt_data,
   output logic [15:0]     t,
   output logic            run,
   output logic            r_flag,
   output logic            ien,
   output logic            fgi,
   output logic            fgo,
   output logic [IO_W-1:0] inpr
);

   logic [3:0]      sc_r,   sc_s;
   logic            s_r,    s_s;
   logic            r_r,    r_s;
   logic            ien_r,  ien_s;
   logic            fgi_r,  fgi_s;
   logic            fgo_r,  fgo_s;
   logic [IO_W-1:0] inpr_r, inpr_s;
   logic [IO_W-1:0] outr_r, outr_s;
   logic            rt2_s;
   logic            early_s;

   // Timing decode and interrupt-cycle qualifiers from the current state.
   always_comb begin
      t       = 16'h0000;
      rt2_s   = 1'b0;
      early_s = 1'b0;
      if (s_r) begin
         t       = 16'h0001 << sc_r;
         rt2_s   = r_r & (sc_r == 4'd2);
         early_s = (sc_r < 4'd3);
      end else begin
         t       = 16'h0000;
      end
   end

   // Next-state logic for the counter, run flag, interrupt and I/O flags.
   always_comb begin
      sc_s   = sc_r;
      s_s    = s_r;
      r_s    = r_r;
      ien_s  = ien_r;
      fgi_s  = fgi_r;
      fgo_s  = fgo_r;
      inpr_s = inpr_r;
      outr_s = outr_r;

      if (hlt) begin
         sc_s = 4'd0;
         s_s  = 1'b0;
      end else if (s_r) begin
         if (sc_clr || rt2_s) begin
            sc_s = 4'd0;
         end else begin
            sc_s = sc_r + 4'd1;
         end
      end else begin
         sc_s = sc_r;
      end

      if (!hlt && start) begin
         s_s = 1'b1;
      end else begin
         s_s = s_s;
      end

      // R is only recognised outside T0..T2 so a fetch is never split.
      if (rt2_s) begin
         r_s = 1'b0;
      end else if (s_r && ien_r && (fgi_r || fgo_r) && !early_s && !r_r) begin
         r_s = 1'b1;
      end else begin
         r_s = r_r;
      end

      if (rt2_s || iof) begin
         ien_s = 1'b0;
      end else if (ion) begin
         ien_s = 1'b1;
      end else begin
         ien_s = ien_r;
      end

      if (kbd_valid && !fgi_r) begin
         fgi_s  = 1'b1;
         inpr_s = kbd_data;
      end else if (inp_ack) begin
         fgi_s  = 1'b0;
      end else begin
         fgi_s  = fgi_r;
      end

      if (out_load && fgo_r) begin
         fgo_s  = 1'b0;
         outr_s = ac_low;
      end else if (!fgo_r && prt_ready) begin
         fgo_s  = 1'b1;
      end else begin
         fgo_s  = fgo_r;
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         sc_r   <= 4'd0;
         s_r    <= 1'b0;
         r_r    <= 1'b0;
         ien_r  <= 1'b0;
         fgi_r  <= 1'b0;
         fgo_r  <= 1'b1;
         inpr_r <= {IO_W{1'b0}};
         outr_r <= {IO_W{1'b0}};
      end else begin
         sc_r   <= sc_s;
         s_r    <= s_s;
         r_r    <= r_s;
         ien_r  <= ien_s;
         fgi_r  <= fgi_s;
         fgo_r  <= fgo_s;
         inpr_r <= inpr_s;
         outr_r <= outr_s;
      end
   end

   assign kbd_ready = ~fgi_r;
   assign prt_valid = ~fgo_r;
   assign prt_data  = outr_r;
   assign run       = s_r;
   assign r_flag    = r_r;
   assign ien       = ien_r;
   assign fgi       = fgi_r;
   assign fgo       = fgo_r;
   assign inpr      = inpr_r;

endmodule

// File: tb/tb_timing_interrupt_sequencer.sv
// Bench for timing_interrupt_sequencer: directed scenarios plus random
// stimulus, all outputs compared every cycle against a behavioural model.
module tb_timing_interrupt_sequencer;

   logic       clk = 1'b0;
   logic       rst, start, hlt, sc_clr, ion, iof, inp_ack, out_load;
   logic [7:0] ac_low, kbd_data;
   logic       kbd_valid, prt_ready;
   logic       kbd_ready, prt_valid, run, r_flag, ien, fgi, fgo;
   logic [7:0] prt_data, inpr;
   logic [15:0] t;

   int n_cmp = 0;
   int n_err = 0;

   // behavioural model state
   int         m_sc  = 0;
   bit         m_s   = 0, m_r = 0, m_ien = 0, m_fgi = 0, m_fgo = 1;
   logic [7:0] m_inpr = 8'h00, m_outr = 8'h00;

   timing_interrupt_sequencer #(.IO_W(8)) dut (
      .clk(clk), .rst(rst), .start(start), .hlt(hlt), .sc_clr(sc_clr),
      .ion(ion), .iof(iof), .inp_ack(inp_ack), .out_load(out_load),
      .ac_low(ac_low), .kbd_valid(kbd_valid), .kbd_data(kbd_data),
      .kbd_ready(kbd_ready), .prt_valid(prt_valid), .prt_ready(prt_ready),
      .prt_data(prt_data), .t(t), .run(run), .r_flag(r_flag), .ien(ien),
      .fgi(fgi), .fgo(fgo), .inpr(inpr)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_step();
      int         n_sc;
      bit         n_s, n_r, n_ien, n_fgi, n_fgo, rt2, early;
      logic [7:0] n_inpr, n_outr;
      if (rst) begin
         m_sc = 0; m_s = 0; m_r = 0; m_ien = 0; m_fgi = 0; m_fgo = 1;
         m_inpr = 8'h00; m_outr = 8'h00;
         return;
      end
      rt2   = m_r && m_s && (m_sc == 2);
      early = m_s && (m_sc <= 2);
      n_sc = m_sc; n_s = m_s; n_fgi = m_fgi; n_fgo = m_fgo;
      n_inpr = m_inpr; n_outr = m_outr;
      if (hlt) begin
         n_sc = 0; n_s = 0;
      end else begin
         if (m_s) n_sc = (sc_clr || rt2) ? 0 : (m_sc + 1) % 16;
         if (start) n_s = 1;
      end
      n_r   = rt2 ? 0 : (m_r || (m_s && m_ien && (m_fgi || m_fgo) && !early));
      n_ien = (rt2 || iof) ? 0 : (ion ? 1 : m_ien);
      if (kbd_valid && !m_fgi) begin
         n_fgi = 1; n_inpr = kbd_data;
      end else if (inp_ack) n_fgi = 0;
      if (out_load && m_fgo) begin
         n_fgo = 0; n_outr = ac_low;
      end else if (!m_fgo && prt_ready) n_fgo = 1;
      m_sc = n_sc; m_s = n_s; m_r = n_r; m_ien = n_ien; m_fgi = n_fgi;
      m_fgo = n_fgo; m_inpr = n_inpr; m_outr = n_outr;
   endtask

   task automatic compare_all();
      check_eq("t",         32'(t),         m_s ? (32'd1 << m_sc) : 32'd0);
      check_eq("run",       32'(run),       32'(m_s));
      check_eq("r_flag",    32'(r_flag),    32'(m_r));
      check_eq("ien",       32'(ien),       32'(m_ien));
      check_eq("fgi",       32'(fgi),       32'(m_fgi));
      check_eq("fgo",       32'(fgo),       32'(m_fgo));
      check_eq("kbd_ready", 32'(kbd_ready), 32'(!m_fgi));
      check_eq("prt_valid", 32'(prt_valid), 32'(!m_fgo));
      check_eq("inpr",      32'(inpr),      32'(m_inpr));
      check_eq("prt_data",  32'(prt_data),  32'(m_outr));
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      compare_all();
   endtask

   task automatic idle_inputs();
      rst = 1'b0; start = 1'b0; hlt = 1'b0; sc_clr = 1'b0; ion = 1'b0;
      iof = 1'b0; inp_ack = 1'b0; out_load = 1'b0; kbd_valid = 1'b0;
      prt_ready = 1'b0; ac_low = 8'h00; kbd_data = 8'h00;
   endtask

   initial begin
      idle_inputs();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_eq("rst_t",    32'(t), 32'h0);
      check_eq("rst_krdy", 32'(kbd_ready), 32'h1);
      check_eq("rst_pval", 32'(prt_valid), 32'h0);

      // sequencing and wrap
      start = 1'b1; tick(); start = 1'b0;
      check_eq("start_t0", 32'(t), 32'h0001);
      for (int i = 1; i <= 16; i++) begin
         tick();
         check_eq("seq_t", 32'(t), 32'h1 << (i % 16));
      end
      repeat (4) tick();
      check_eq("at_t4", 32'(t), 32'h0010);
      sc_clr = 1'b1; tick(); sc_clr = 1'b0;
      check_eq("clr_t0", 32'(t), 32'h0001);

      // halt and restart
      repeat (3) tick();
      hlt = 1'b1; tick(); hlt = 1'b0;
      check_eq("hlt_t", 32'(t), 32'h0);
      tick();
      check_eq("hlt_run", 32'(run), 32'h0);
      start = 1'b1; tick(); start = 1'b0;
      check_eq("restart", 32'(t), 32'h0001);
      hlt = 1'b1; start = 1'b1; tick(); hlt = 1'b0; start = 1'b0;
      tick();
      check_eq("hlt_start", 32'(run), 32'h0);

      // keyboard handshake
      kbd_valid = 1'b1; kbd_data = 8'h41; tick();
      check_eq("kbd_inpr", 32'(inpr), 32'h41);
      kbd_data = 8'h42; tick(); kbd_valid = 1'b0;
      check_eq("kbd_hold", 32'(inpr), 32'h41);
      inp_ack = 1'b1; tick(); inp_ack = 1'b0;
      check_eq("kbd_ack", 32'(kbd_ready), 32'h1);

      // printer handshake
      out_load = 1'b1; ac_low = 8'h5A; tick();
      check_eq("prt_data", 32'(prt_data), 32'h5A);
      ac_low = 8'h00; tick(); out_load = 1'b0;
      check_eq("prt_ign", 32'(prt_data), 32'h5A);
      prt_ready = 1'b1; tick(); prt_ready = 1'b0;
      check_eq("prt_done", 32'(prt_valid), 32'h0);
      out_load = 1'b1; ac_low = 8'h33; tick(); out_load = 1'b0;

      // interrupt at T5
      start = 1'b1; tick(); start = 1'b0;
      ion = 1'b1; tick(); ion = 1'b0;
      repeat (3) tick();
      check_eq("pre_t4", 32'(t), 32'h0010);
      kbd_valid = 1'b1; kbd_data = 8'h77; tick(); kbd_valid = 1'b0;
      check_eq("t5_r0", 32'(r_flag), 32'h0);
      tick();
      check_eq("t6_r1", 32'(r_flag), 32'h1);
      sc_clr = 1'b1; tick(); sc_clr = 1'b0;
      check_eq("rt0", 32'(t), 32'h0001);
      tick(); tick();
      check_eq("rt2", 32'(t), 32'h0004);
      tick();
      check_eq("rt_end_r", 32'(r_flag), 32'h0);
      check_eq("rt_end_ien", 32'(ien), 32'h0);
      check_eq("rt_end_t", 32'(t), 32'h0001);
      ion = 1'b1; iof = 1'b1; tick(); ion = 1'b0; iof = 1'b0;
      check_eq("ion_iof", 32'(ien), 32'h0);

      // interrupt request raised during T1 waits for T3
      inp_ack = 1'b1; tick(); inp_ack = 1'b0;
      ion = 1'b1; tick(); ion = 1'b0;
      sc_clr = 1'b1; tick(); sc_clr = 1'b0;
      kbd_valid = 1'b1; tick(); kbd_valid = 1'b0;
      check_eq("t1_r0", 32'(r_flag), 32'h0);
      tick();
      check_eq("t2_r0", 32'(r_flag), 32'h0);
      tick();
      check_eq("t3_r0", 32'(r_flag), 32'h0);
      tick();
      check_eq("t4_r1", 32'(r_flag), 32'h1);

      // random phase
      for (int i = 0; i < 4000; i++) begin
         rst       = ($urandom_range(0, 299) == 0);
         start     = ($urandom_range(0, 5) == 0);
         hlt       = ($urandom_range(0, 39) == 0);
         sc_clr    = ($urandom_range(0, 7) == 0);
         ion       = ($urandom_range(0, 7) == 0);
         iof       = ($urandom_range(0, 15) == 0);
         inp_ack   = ($urandom_range(0, 3) == 0);
         out_load  = ($urandom_range(0, 3) == 0);
         kbd_valid = ($urandom_range(0, 1) == 0);
         prt_ready = ($urandom_range(0, 2) == 0);
         ac_low    = 8'($urandom);
         kbd_data  = 8'($urandom);
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
